// File: rtl/store_buffer_if.sv
// Store buffer bus bundle.
//   slave  : buffer side. It receives the store, load-check and Mem_Ready
//            inputs and drives Store_Ready, Load_Hazard, Mem_* and Count/Empty.
//   master : core/memory side, the mirror image of slave.
// DEPTH must match the DEPTH of the store_buffer that uses this interface.
interface store_buffer_if #(parameter int DEPTH = 4);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          Store_Valid;
  logic [31:0]   Store_Addr;
  logic [31:0]   Store_Data;
  logic [3:0]    Store_Ctrl;
  logic          Store_Ready;
  logic          Load_Check_Valid;
  logic [31:0]   Load_Check_Addr;
  logic          Load_Hazard;
  logic          Mem_Valid;
  logic [31:0]   Mem_Addr;
  logic [31:0]   Mem_Data;
  logic [3:0]    Mem_Byte_En;
  logic          Mem_Ready;
  logic [CW-1:0] Count;
  logic          Empty;

  modport slave (
    input  Store_Valid, Store_Addr, Store_Data, Store_Ctrl,
    input  Load_Check_Valid, Load_Check_Addr, Mem_Ready,
    output Store_Ready, Load_Hazard, Mem_Valid, Mem_Addr, Mem_Data,
    output Mem_Byte_En, Count, Empty
  );

  modport master (
    output Store_Valid, Store_Addr, Store_Data, Store_Ctrl,
    output Load_Check_Valid, Load_Check_Addr, Mem_Ready,
    input  Store_Ready, Load_Hazard, Mem_Valid, Mem_Addr, Mem_Data,
    input  Mem_Byte_En, Count, Empty
  );
endinterface

// File: rtl/store_buffer.sv
// Posted-write store buffer. It is a circular FIFO of {word addr, data, byte
// enables}. A store to the same word as the newest non-head entry merges into
// that entry. The head entry drains over Mem_Valid/Mem_Ready. Load_Hazard flags
// a load whose word is still pending in the buffer.
// Ports: Clk, Reset (async, active-high), bus (store_buffer_if.slave).
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic           Clk,
  input  logic           Reset,
  store_buffer_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [29:0] waddr;
    logic [31:0] data;
    logic [3:0]  be;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   head, tail, newest, off;
  logic [CW-1:0]   count, count_nxt;
  logic            full, accept, merge, push, deq, hz;

  assign full   = (count == CW'(DEPTH));
  assign newest = tail - 1'b1;
  assign accept = bus.Store_Valid && !full && (bus.Store_Ctrl != 4'b0000);
  // Merging needs count >= 2, so the head entry is never merged into and the
  // pending Mem_* handshake stays stable. The check uses pre-edge state.
  assign merge  = accept && (count >= CW'(2)) &&
                  (mem[newest].waddr == bus.Store_Addr[31:2]);
  assign push   = accept && !merge;
  assign deq    = (count != '0) && bus.Mem_Ready;

  assign count_nxt = count + (push ? CW'(1) : CW'(0)) - (deq ? CW'(1) : CW'(0));

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[tail] <= '{waddr: bus.Store_Addr[31:2], data: bus.Store_Data,
                       be: bus.Store_Ctrl};
        tail      <= tail + 1'b1;
      end
      if (merge) begin
        for (int l = 0; l < 4; l++)
          if (bus.Store_Ctrl[l]) mem[newest].data[l*8 +: 8] <= bus.Store_Data[l*8 +: 8];
        mem[newest].be <= mem[newest].be | bus.Store_Ctrl;
      end
      if (deq) head <= head + 1'b1;
      count <= count_nxt;
    end
  end

  // An entry is live when its distance from head, modulo DEPTH, is below count.
  always_comb begin
    hz  = 1'b0;
    off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = AW'(i) - head;
      if (({1'b0, off} < count) && (mem[i].waddr == bus.Load_Check_Addr[31:2]))
        hz = 1'b1;
    end
  end

  assign bus.Load_Hazard = bus.Load_Check_Valid && hz;
  assign bus.Store_Ready = !full;
  assign bus.Count       = count;
  assign bus.Empty       = (count == '0);
  assign bus.Mem_Valid   = (count != '0);
  assign bus.Mem_Addr    = {mem[head].waddr, 2'b00};
  assign bus.Mem_Data    = mem[head].data;
  assign bus.Mem_Byte_En = mem[head].be;
endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;
  localparam int DEPTH = 4;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  store_buffer_if #(.DEPTH(DEPTH)) bus ();
  store_buffer #(.DEPTH(DEPTH)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));

  typedef struct {
    logic [29:0] w;
    logic [31:0] d;
    logic [3:0]  be;
  } ent_t;

  ent_t mq[$];     // reference FIFO contents
  ent_t exp_q[$];  // predicted drain order
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Reference model. Inputs are stable between posedge+1 and the next posedge,
  // so at negedge the model checks the DUT outputs and predicts the next edge.
  always @(negedge Clk) begin
    if (!Reset) begin
      logic full, acc, mrg, dq, hz;
      ent_t e;
      full = (mq.size() == DEPTH);
      hz = 1'b0;
      foreach (mq[i]) if (mq[i].w == bus.Load_Check_Addr[31:2]) hz = 1'b1;
      chk("count", 32'(bus.Count), 32'(mq.size()));
      chk("store_ready", 32'(bus.Store_Ready), 32'(!full));
      chk("empty", 32'(bus.Empty), 32'(mq.size() == 0));
      chk("mem_valid", 32'(bus.Mem_Valid), 32'(mq.size() != 0));
      chk("load_hazard", 32'(bus.Load_Hazard), 32'(bus.Load_Check_Valid && hz));
      if (mq.size() != 0) chk("head_addr", bus.Mem_Addr, {mq[0].w, 2'b00});
      dq  = (mq.size() != 0) && bus.Mem_Ready;
      acc = bus.Store_Valid && !full && (bus.Store_Ctrl != 4'b0000);
      mrg = acc && (mq.size() >= 2) && (mq[$].w == bus.Store_Addr[31:2]);
      if (dq) exp_q.push_back(mq[0]);
      if (mrg) begin
        e = mq[$];
        for (int l = 0; l < 4; l++)
          if (bus.Store_Ctrl[l]) e.d[l*8 +: 8] = bus.Store_Data[l*8 +: 8];
        e.be = e.be | bus.Store_Ctrl;
        mq[$] = e;
      end
      if (dq) void'(mq.pop_front());
      if (acc && !mrg)
        mq.push_back('{w: bus.Store_Addr[31:2], d: bus.Store_Data, be: bus.Store_Ctrl});
    end
  end

  // Monitor: every handshake observed on the memory side pops one prediction.
  always @(negedge Clk) begin
    #1;
    if (!Reset && bus.Mem_Valid && bus.Mem_Ready) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL drain_unexpected actual addr=%h required=none", bus.Mem_Addr);
      end else begin
        ent_t e;
        e = exp_q.pop_front();
        chk("drain_addr", bus.Mem_Addr, {e.w, 2'b00});
        chk("drain_data", bus.Mem_Data, e.d);
        chk("drain_be", 32'(bus.Mem_Byte_En), 32'(e.be));
      end
    end
  end

  task automatic cyc(input logic sv, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] c, input logic mr,
                     input logic lv = 1'b0, input logic [31:0] la = 32'h0);
    bus.Store_Valid = sv; bus.Store_Addr = a; bus.Store_Data = d; bus.Store_Ctrl = c;
    bus.Mem_Ready = mr; bus.Load_Check_Valid = lv; bus.Load_Check_Addr = la;
    @(posedge Clk); #1;
  endtask

  initial begin
    logic [31:0] words [4];
    words = '{32'h100, 32'h104, 32'h108, 32'h10C};
    Reset = 1'b1;
    bus.Store_Valid = 0; bus.Store_Addr = 0; bus.Store_Data = 0; bus.Store_Ctrl = 0;
    bus.Mem_Ready = 0; bus.Load_Check_Valid = 0; bus.Load_Check_Addr = 0;
    #12;
    chk("rst_count", 32'(bus.Count), 0);
    chk("rst_empty", 32'(bus.Empty), 1);
    chk("rst_ready", 32'(bus.Store_Ready), 1);
    chk("rst_mem_valid", 32'(bus.Mem_Valid), 0);
    chk("rst_mem_addr", bus.Mem_Addr, 0);
    chk("rst_mem_data", bus.Mem_Data, 0);
    chk("rst_mem_be", 32'(bus.Mem_Byte_En), 0);
    chk("rst_hazard", 32'(bus.Load_Hazard), 0);
    Reset = 1'b0;
    @(posedge Clk); #1;

    // Single store, latency and hold while memory stalls
    cyc(1, 32'h104, 32'h0000AB00, 4'b0010, 0);
    chk("lat_valid", 32'(bus.Mem_Valid), 1);
    chk("lat_addr", bus.Mem_Addr, 32'h104);
    chk("lat_be", 32'(bus.Mem_Byte_En), 32'h2);
    chk("lat_count", 32'(bus.Count), 1);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 0, 0);
      chk("hold_data", bus.Mem_Data, 32'h0000AB00);
    end
    cyc(0, 0, 0, 0, 1);
    chk("drain_empty", 32'(bus.Empty), 1);

    // Merge into the newest non-head entry
    cyc(1, 32'h10, 32'hDEADBEEF, 4'b1111, 0);
    cyc(1, 32'h20, 32'h00000011, 4'b0001, 0);
    cyc(1, 32'h20, 32'h22000000, 4'b1000, 0);
    chk("merge_count", 32'(bus.Count), 2);
    cyc(0, 0, 0, 0, 1);
    chk("merge_data", bus.Mem_Data, 32'h22000011);
    chk("merge_be", 32'(bus.Mem_Byte_En), 32'h9);
    cyc(0, 0, 0, 0, 1);

    // Full, blocked store during a dequeue, pointer wrap
    for (int i = 0; i < 4; i++) cyc(1, 32'h200 + 32'(i*4), $urandom, 4'b1111, 0);
    chk("full_ready", 32'(bus.Store_Ready), 0);
    cyc(1, 32'h210, 32'h55555555, 4'b1111, 1);
    chk("full_blocked", 32'(bus.Count), 3);
    cyc(1, 32'h210, 32'h55555555, 4'b1111, 0);
    chk("full_retry", 32'(bus.Count), 4);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1);

    // Load hazard
    cyc(1, 32'h40, 32'h12345678, 4'b1111, 0);
    bus.Store_Valid = 0; bus.Load_Check_Valid = 1; bus.Load_Check_Addr = 32'h42; #1;
    chk("hz_hit", 32'(bus.Load_Hazard), 1);
    bus.Load_Check_Addr = 32'h44; #1;
    chk("hz_miss", 32'(bus.Load_Hazard), 0);
    cyc(0, 0, 0, 0, 1, 1, 32'h40);
    chk("hz_gone", 32'(bus.Load_Hazard), 0);

    // Zero byte enables are dropped
    cyc(1, 32'h80, 32'hFFFFFFFF, 4'b0000, 0);
    chk("zero_ctrl_count", 32'(bus.Count), 0);
    chk("zero_ctrl_valid", 32'(bus.Mem_Valid), 0);

    // Asynchronous reset mid-cycle
    for (int i = 0; i < 3; i++) cyc(1, 32'h300 + 32'(i*4), $urandom, 4'b1111, 0);
    cyc(0, 0, 0, 0, 0);
    #1 Reset = 1'b1; mq.delete();
    #1;
    chk("arst_count", 32'(bus.Count), 0);
    chk("arst_valid", 32'(bus.Mem_Valid), 0);
    chk("arst_ready", 32'(bus.Store_Ready), 1);
    Reset = 1'b0;
    @(posedge Clk); #1;

    // Randomized traffic over a few words so merges and hazards happen often
    for (int n = 0; n < 400; n++)
      cyc(($urandom_range(0, 9) < 7), words[$urandom_range(0, 3)] | 32'($urandom_range(0, 3)),
          $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 1) == 1,
          $urandom_range(0, 1) == 1, words[$urandom_range(0, 3)]);
    for (int n = 0; n < DEPTH + 2; n++) cyc(0, 0, 0, 0, 1);
    chk("final_empty", 32'(bus.Count), 0);
    chk("final_scoreboard", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
